instr_fetch_stage: RTL

- Stage0 datapath block. Fetches the instruction at program_counter and expands it into decoded fields for stages 1–3.
- Triggered by the stage0 strobe derived from the 4-phase stage clocking.
- Reads a byte-wide instruction ROM over a req/ack interface, assembles INSTR_BYTES bytes, and presents the expanded instruction with a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch_stage_if.sv | 34 +++
 rtl/instr_fetch_stage_expand.sv | 22 ++
 rtl/instr_fetch_stage.sv | 107 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, FSM encoding and instruction layout.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_BYTES = 4;
    localparam int IDX_W       = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, VALID} state_e;

    // Opcode byte sub-fields
    localparam int OPC_SRC0_HI = 7;
    localparam int OPC_SRC0_LO = 6;
    localparam int OPC_SRC1_HI = 5;
    localparam int OPC_SRC1_LO = 4;
    localparam int OPC_ALU_HI  = 3;
    localparam int OPC_ALU_LO  = 0;

    // Byte positions within the assembled instruction
    localparam int OPCODE = 0;
    localparam int OP0    = 1;
    localparam int OP1    = 2;
    localparam int DST    = 3;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// ROM read bus plus the expanded-instruction valid/ready bus of the fetch stage.
interface instr_fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        opcode;
    logic [1:0]        src0_mode;
    logic [1:0]        src1_mode;
    logic [3:0]        alu_op;
    logic [7:0]        operand0;
    logic [7:0]        operand1;
    logic [7:0]        dst;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, opcode, src0_mode, src1_mode,
               alu_op, operand0, operand1, dst, instr_pc,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, opcode, src0_mode, src1_mode,
               alu_op, operand0, operand1, dst, instr_pc,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch_stage_expand.sv
// Splits the assembled instruction bytes into decoded fields; the only place
// that knows the instruction layout.
module instr_expand
    import cpu_pkg::*;
(
    input  logic [INSTR_BYTES-1:0][7:0] bytes_i,
    output logic [7:0]                  opcode_o,
    output logic [1:0]                  src0_mode_o,
    output logic [1:0]                  src1_mode_o,
    output logic [3:0]                  alu_op_o,
    output logic [7:0]                  operand0_o,
    output logic [7:0]                  operand1_o,
    output logic [7:0]                  dst_o
);
    assign opcode_o    = bytes_i[OPCODE];
    assign src0_mode_o = bytes_i[OPCODE][OPC_SRC0_HI:OPC_SRC0_LO];
    assign src1_mode_o = bytes_i[OPCODE][OPC_SRC1_HI:OPC_SRC1_LO];
    assign alu_op_o    = bytes_i[OPCODE][OPC_ALU_HI:OPC_ALU_LO];
    assign operand0_o  = bytes_i[OP0];
    assign operand1_o  = bytes_i[OP1];
    assign dst_o       = bytes_i[DST];
endmodule

// File: rtl/instr_fetch_stage.sv
// Stage0 fetch: reads INSTR_BYTES bytes from a byte ROM over req/ack starting
// at the sampled pc, then holds the expanded instruction under valid/ready.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_start,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                flush,
    instr_fetch_stage_if.master bus,
    output logic                busy,
    output logic                overrun
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

    state_e                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [ADDR_W-1:0]            base_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [ADDR_W-1:0]            ipc_q;
    logic                         req_q;
    logic                         valid_q;
    logic                         overrun_q;
    logic [INSTR_BYTES-1:0][7:0]  asm_q;
    logic [INSTR_BYTES-1:0][7:0]  instr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            ipc_q     <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            asm_q     <= '0;
            instr_q   <= '0;
        end else begin
            overrun_q <= fetch_start && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (fetch_start && !flush) begin
                        state_q <= REQ;
                        base_q  <= pc;
                        addr_q  <= pc;
                        idx_q   <= '0;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    // A flush discards any ack that lands in the same cycle.
                    if (flush) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else if (bus.mem_ack) begin
                        asm_q[idx_q] <= bus.mem_rdata;
                        idx_q        <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            // Fields change only here, so they stay stable in VALID/IDLE.
                            state_q                  <= VALID;
                            req_q                    <= 1'b0;
                            valid_q                  <= 1'b1;
                            instr_q                  <= asm_q;
                            instr_q[INSTR_BYTES-1]   <= bus.mem_rdata;
                            ipc_q                    <= base_q;
                        end else begin
                            addr_q <= base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                        end
                    end
                end
                VALID: begin
                    if (flush || bus.instr_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_pc    = ipc_q;
    assign busy            = (state_q != IDLE);
    assign overrun         = overrun_q;

    instr_expand u_expand (
        .bytes_i     (instr_q),
        .opcode_o    (bus.opcode),
        .src0_mode_o (bus.src0_mode),
        .src1_mode_o (bus.src1_mode),
        .alu_op_o    (bus.alu_op),
        .operand0_o  (bus.operand0),
        .operand1_o  (bus.operand1),
        .dst_o       (bus.dst)
    );
endmodule
